// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer ALU with a valid/ready handshake on
// both sides. Arithmetic and logic ops finish one cycle after accept; shifts
// are performed one bit per cycle, so a shift by n takes n+1 cycles.
// The result is held in DONE until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  // Operation codes
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;       // registered opcode (selects shift direction)
  logic [WIDTH-1:0] sh_q, sh_d;       // registered operand A, shifted in place
  logic [4:0]       cnt_q, cnt_d;     // remaining shift steps (registered b[4:0])
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             in_is_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] sh_step;

  assign accept      = in_valid && in_ready;
  assign in_is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // Single-cycle ALU evaluated on the operands presented at accept
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      // Sign of the difference corrected by overflow gives the true signed compare
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // A shift by zero completes immediately with A unchanged
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_res = '0;  // illegal opcodes produce 0
    endcase
  end

  // One-bit shift step of the working register, direction from the stored opcode
  always_comb begin
    sh_step = sh_q;
    case (op_q)
      OP_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_step = {1'b0, sh_q[WIDTH-1:1]};
      OP_SRA:  sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_step = sh_q;
    endcase
  end

  // Next-state and datapath-update logic for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op;
          sh_d  = a;
          cnt_d = b[4:0];
          if (in_is_shift && (b[4:0] != 5'd0)) begin
            state_d = ST_SHIFT;
          end else begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          res_d   = sh_step;
          zero_d  = (sh_step == '0);
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Result is held until taken; leaving DONE clears it so it reads 0 elsewhere
        if (out_ready) begin
          res_d   = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        res_d   = '0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      sh_q    <= '0;
      cnt_q   <= 5'd0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, hand-written
// reset/backpressure sequences, and random ops checked against a model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: straight from the op definitions, using wide arithmetic
  function automatic void model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] r, output logic z, output logic v,
                                output int lat);
    longint sa, sb, s;
    int     n;
    sa  = $signed(av);
    sb  = $signed(bv);
    n   = int'(bv[4:0]);
    r   = 32'd0;
    v   = 1'b0;
    lat = 1;
    case (o)
      4'd0: begin s = sa + sb; r = av + bv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; r = av - bv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd3: r = (av < bv) ? 32'd1 : 32'd0;
      4'd4: r = av & bv;
      4'd5: r = av | bv;
      4'd6: r = av ^ bv;
      4'd7: begin r = av << n; lat = n + 1; end
      4'd8: begin r = av >> n; lat = n + 1; end
      4'd9: begin r = $signed(av) >>> n; lat = n + 1; end
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  // Full transaction: offer, accept, wait (bounded), check, hold under backpressure, release
  task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic ez, input logic ev,
                       input int el, input int hold);
    int lat;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_result", result, 32'd0);
    op        = o;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      chk("busy_ready", {31'd0, in_ready}, 32'd0);
      chk("busy_result", result, 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      op       = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      lat++;
    end
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("latency", lat, el);
    chk("result", result, er);
    chk("zero", {31'd0, zero}, {31'd0, ez});
    chk("ovf", {31'd0, ovf}, {31'd0, ev});
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op       = 4'd0;
      a        = $urandom;
      b        = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, er);
      chk("hold_flags", {30'd0, zero, ovf}, {30'd0, ez, ev});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    chk("release_result", result, 32'd0);
    $display("txn op=%0d a=0x%08h b=0x%08h result=0x%08h zero=%0d ovf=%0d lat=%0d hold=%0d",
             o, av, bv, er, ez, ev, lat, hold);
  endtask

  initial begin
    logic [31:0] mr;
    logic        mz, mv;
    int          ml;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        saw_stale;

    //            op     a             b             res           z     v     lat hold
    tbl[0]  = '{4'd2, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tbl[1]  = '{4'd2, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tbl[2]  = '{4'd3, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tbl[3]  = '{4'd2, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1,  1};
    tbl[4]  = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1,  0};
    tbl[5]  = '{4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tbl[6]  = '{4'd9, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32, 0};
    tbl[7]  = '{4'd7, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tbl[8]  = '{4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1,  5};
    tbl[9]  = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1, 0};
    tbl[10] = '{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1,  0};
    tbl[11] = '{4'd7, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, 1'b0, 1'b0, 5,  2};
    tbl[12] = '{4'd8, 32'h80000000, 32'h00000003, 32'h10000000, 1'b0, 1'b0, 4,  0};
    tbl[13] = '{4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1,  0};
    tbl[14] = '{4'd5, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1,  0};
    tbl[15] = '{4'd6, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0, 1,  0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {result[30:0], zero}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the first entry is accepted on the first edge after reset release
    for (int i = 0; i < 16; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].zero, tbl[i].ovf,
            tbl[i].lat, tbl[i].hold);

    // Reset in the middle of a long shift
    op       = 4'd8;
    a        = 32'hFFFFFFFF;
    b        = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", {30'd0, zero, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    saw_stale = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_stale = 1'b1;
    end
    chk("no_stale_valid", {31'd0, saw_stale}, 32'd0);
    do_op(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 0);

    // Reset while holding a result in DONE
    op       = 4'd0;
    a        = 32'd7;
    b        = 32'd8;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_done", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("done_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("done_rst_after", {31'd0, out_valid}, 32'd0);

    // Random operations against the reference model
    for (int k = 0; k < 60; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ((k % 5) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
      if ((k % 7) == 0) rb = ra;
      model(ro, ra, rb, mr, mz, mv, ml);
      do_op(ro, ra, rb, mr, mz, mv, ml, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
